// File: rtl/range_monitor_real.sv
// rtl/range_monitor_real.sv - multi-channel fixed-point range monitor with sticky flags, counters, peaks and first-violation capture
// Each word means word * 2^EXPONENT; a channel violates when its word lies outside +/-LIMIT.
module range_monitor_real #(
  parameter int    N_CH       = 4,
  parameter int    WIDTH      = 16,
  parameter int    EXPONENT   = -8,
  parameter real   RANGE      = 10.0,
  parameter int    CNT_WIDTH  = 8,
  parameter int    FATAL_MODE = 0,
  parameter string NAME       = "name",
  localparam int   CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cke,
  input  logic                      clear,
  input  logic [N_CH*WIDTH-1:0]     in,
  output logic [N_CH-1:0]           viol_now,
  output logic [N_CH-1:0]           viol_sticky,
  output logic                      any_viol,
  output logic [N_CH*CNT_WIDTH-1:0] viol_count,
  output logic [N_CH*WIDTH-1:0]     peak_abs,
  output logic                      first_valid,
  output logic [CH_W-1:0]           first_chan,
  output logic [WIDTH-1:0]          first_value
);

  // Bound in word units, floored and clamped to the largest positive word.
  localparam real SCALED  = RANGE * (2.0 ** (-EXPONENT));
  localparam real MAX_POS = (2.0 ** (WIDTH - 1)) - 1.0;
  localparam int  LIMIT_I = (SCALED >= MAX_POS) ? $rtoi(MAX_POS) : $rtoi(SCALED);
  localparam logic signed [WIDTH-1:0] LIMIT     = WIDTH'(LIMIT_I);
  localparam logic signed [WIDTH-1:0] NEG_LIMIT = -LIMIT;

  if (RANGE <= 0.0) begin : g_bad_range
    $error("range_monitor_real: RANGE must be positive");
  end

  logic signed [WIDTH-1:0] word [N_CH];
  logic [WIDTH-1:0]        mag  [N_CH];
  logic [N_CH-1:0]         viol;

  logic [N_CH-1:0]         viol_now_q;
  logic [N_CH-1:0]         sticky_q;
  logic [CNT_WIDTH-1:0]    cnt_q  [N_CH];
  logic [WIDTH-1:0]        peak_q [N_CH];
  logic                    first_valid_q;
  logic [CH_W-1:0]         first_chan_q;
  logic [WIDTH-1:0]        first_value_q;

  logic                    hit;
  logic [CH_W-1:0]         hit_chan;
  logic [WIDTH-1:0]        hit_value;

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    assign word[k] = in[k*WIDTH +: WIDTH];
    assign viol[k] = (word[k] > LIMIT) || (word[k] < NEG_LIMIT);
    // Negating the most negative word wraps to itself, which is the exact unsigned magnitude.
    assign mag[k]  = word[k][WIDTH-1] ? $unsigned(-word[k]) : $unsigned(word[k]);

    assign viol_count[k*CNT_WIDTH +: CNT_WIDTH] = cnt_q[k];
    assign peak_abs[k*WIDTH +: WIDTH]           = peak_q[k];
  end

  // Descending scan so the lowest violating channel is the last assignment and wins.
  always_comb begin
    hit       = 1'b0;
    hit_chan  = '0;
    hit_value = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (viol[k]) begin
        hit       = 1'b1;
        hit_chan  = CH_W'(k);
        hit_value = word[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      viol_now_q    <= '0;
      sticky_q      <= '0;
      first_valid_q <= 1'b0;
      first_chan_q  <= '0;
      first_value_q <= '0;
      for (int k = 0; k < N_CH; k++) begin
        cnt_q[k]  <= '0;
        peak_q[k] <= '0;
      end
    end else if (cke) begin
      viol_now_q <= viol;
      sticky_q   <= sticky_q | viol;
      for (int k = 0; k < N_CH; k++) begin
        if (viol[k] && (cnt_q[k] != {CNT_WIDTH{1'b1}})) begin
          cnt_q[k] <= cnt_q[k] + 1'b1;
        end
        if (mag[k] > peak_q[k]) begin
          peak_q[k] <= mag[k];
        end
      end
      if (!first_valid_q && hit) begin
        first_valid_q <= 1'b1;
        first_chan_q  <= hit_chan;
        first_value_q <= hit_value;
      end
    end
  end

  assign viol_now    = viol_now_q;
  assign viol_sticky = sticky_q;
  assign any_viol    = |sticky_q;
  assign first_valid = first_valid_q;
  assign first_chan  = first_chan_q;
  assign first_value = first_value_q;

`ifndef SYNTHESIS
  // Sticky 0->1 edges bound reports to one per channel between clears.
  always @(posedge clk) begin
    if (!rst && !clear && cke) begin
      for (int k = 0; k < N_CH; k++) begin
        if (viol[k] && !sticky_q[k]) begin
          $display("%s: channel %0d value %f outside +/-%f", NAME, k,
                   $itor(word[k]) * (2.0 ** EXPONENT), RANGE);
        end
        if ((FATAL_MODE != 0) && viol[k] && !viol_now_q[k]) begin
          $fatal(1, "%s: channel %0d range violation", NAME, k);
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_range_monitor_real.sv
// tb/tb_range_monitor_real.sv - vector table plus randomized model comparison for range_monitor_real
module tb_range_monitor_real;
  localparam int LIM     = 32;
  localparam int CNT_MAX = 3;

  logic        clk = 1'b0;
  logic        rst, cke, clear;
  logic [15:0] in_bus;
  logic [1:0]  viol_now, viol_sticky;
  logic        any_viol;
  logic [3:0]  viol_count;
  logic [15:0] peak_abs;
  logic        first_valid;
  logic [0:0]  first_chan;
  logic [7:0]  first_value;

  range_monitor_real #(
    .N_CH(2), .WIDTH(8), .EXPONENT(-4), .RANGE(2.0),
    .CNT_WIDTH(2), .FATAL_MODE(0), .NAME("tb_mon")
  ) dut (
    .clk(clk), .rst(rst), .cke(cke), .clear(clear), .in(in_bus),
    .viol_now(viol_now), .viol_sticky(viol_sticky), .any_viol(any_viol),
    .viol_count(viol_count), .peak_abs(peak_abs), .first_valid(first_valid),
    .first_chan(first_chan), .first_value(first_value)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit       r, c, e;
    int       w0, w1;
    bit [1:0] now, stk;
    int       c0, c1, p0, p1;
    bit       fv;
    int       fc, fval;
  } vec_t;

  vec_t tbl[$];

  // Abstract model state: plain integers per channel.
  int m_now[2], m_stk[2], m_cnt[2], m_pk[2];
  int m_fv, m_fc, m_fval;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input bit r, input bit c, input bit e, input int w0, input int w1);
    rst    = r;
    clear  = c;
    cke    = e;
    in_bus = {8'(w1), 8'(w0)};
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input bit [1:0] now, input bit [1:0] stk,
                           input int c0, input int c1, input int p0, input int p1,
                           input bit fv, input int fc, input int fval);
    chk({tag, " viol_now"},    32'(viol_now),        32'(now));
    chk({tag, " viol_sticky"}, 32'(viol_sticky),     32'(stk));
    chk({tag, " any_viol"},    32'(any_viol),        32'(stk != 2'b00));
    chk({tag, " count0"},      32'(viol_count[1:0]), 32'(c0));
    chk({tag, " count1"},      32'(viol_count[3:2]), 32'(c1));
    chk({tag, " peak0"},       32'(peak_abs[7:0]),   32'(p0));
    chk({tag, " peak1"},       32'(peak_abs[15:8]),  32'(p1));
    chk({tag, " first_valid"}, 32'(first_valid),     32'(fv));
    chk({tag, " first_chan"},  32'(first_chan),      32'(fc));
    chk({tag, " first_value"}, 32'(first_value),     32'(fval & 8'hFF));
  endtask

  task automatic model_step(input bit r, input bit c, input bit e, input int w0, input int w1);
    int w[2];
    int a;
    bit v;
    w[0] = w0;
    w[1] = w1;
    if (r || c) begin
      for (int k = 0; k < 2; k++) begin
        m_now[k] = 0; m_stk[k] = 0; m_cnt[k] = 0; m_pk[k] = 0;
      end
      m_fv = 0; m_fc = 0; m_fval = 0;
    end else if (e) begin
      for (int k = 0; k < 2; k++) begin
        v = (w[k] > LIM) || (w[k] < -LIM);
        m_now[k] = v;
        if (v) m_stk[k] = 1;
        if (v && m_cnt[k] < CNT_MAX) m_cnt[k]++;
        a = (w[k] < 0) ? -w[k] : w[k];
        if (a > m_pk[k]) m_pk[k] = a;
      end
      if (m_fv == 0) begin
        for (int k = 1; k >= 0; k--) begin
          if ((w[k] > LIM) || (w[k] < -LIM)) begin
            m_fv = 1; m_fc = k; m_fval = w[k];
          end
        end
      end
    end
  endtask

  function automatic int pick_word();
    int edges[8] = '{32, -32, 33, -33, 127, -128, 0, 31};
    if ($urandom_range(0, 1) == 0) return edges[$urandom_range(0, 7)];
    return int'($urandom_range(0, 255)) - 128;
  endfunction

  initial begin
    rst = 1'b1; clear = 1'b0; cke = 1'b0; in_bus = '0;

    tbl.push_back('{1,0,0,   0,    0, 2'b00, 2'b00, 0,0,   0,  0, 0,0,    0});
    tbl.push_back('{0,0,1,  32,    0, 2'b00, 2'b00, 0,0,  32,  0, 0,0,    0});
    tbl.push_back('{0,0,1, -32,    0, 2'b00, 2'b00, 0,0,  32,  0, 0,0,    0});
    tbl.push_back('{0,0,1,  33,    0, 2'b01, 2'b01, 1,0,  33,  0, 1,0,   33});
    tbl.push_back('{0,0,1, -33,    0, 2'b01, 2'b01, 2,0,  33,  0, 1,0,   33});
    tbl.push_back('{0,1,1, 100,    0, 2'b00, 2'b00, 0,0,   0,  0, 0,0,    0});
    tbl.push_back('{0,0,1,  40,  -50, 2'b11, 2'b11, 1,1,  40, 50, 1,0,   40});
    tbl.push_back('{0,0,1,   0,  -60, 2'b10, 2'b11, 1,2,  40, 60, 1,0,   40});
    tbl.push_back('{0,1,1,   0,    0, 2'b00, 2'b00, 0,0,   0,  0, 0,0,    0});
    tbl.push_back('{0,0,1,   0, -128, 2'b10, 2'b10, 0,1,   0,128, 1,1, -128});
    tbl.push_back('{0,0,1,   0, -128, 2'b10, 2'b10, 0,2,   0,128, 1,1, -128});
    tbl.push_back('{0,0,1,   0, -128, 2'b10, 2'b10, 0,3,   0,128, 1,1, -128});
    tbl.push_back('{0,0,1,   0, -128, 2'b10, 2'b10, 0,3,   0,128, 1,1, -128});
    tbl.push_back('{0,0,1,   0, -128, 2'b10, 2'b10, 0,3,   0,128, 1,1, -128});
    tbl.push_back('{0,1,0,   0,    0, 2'b00, 2'b00, 0,0,   0,  0, 0,0,    0});
    tbl.push_back('{0,0,0, 100,    0, 2'b00, 2'b00, 0,0,   0,  0, 0,0,    0});
    tbl.push_back('{0,0,0, 100,    0, 2'b00, 2'b00, 0,0,   0,  0, 0,0,    0});
    tbl.push_back('{0,0,0, 100,    0, 2'b00, 2'b00, 0,0,   0,  0, 0,0,    0});
    tbl.push_back('{0,0,1, 100,    0, 2'b01, 2'b01, 1,0, 100,  0, 1,0,  100});
    tbl.push_back('{0,1,1, 100,    0, 2'b00, 2'b00, 0,0,   0,  0, 0,0,    0});
    tbl.push_back('{0,0,1, -50,    0, 2'b01, 2'b01, 1,0,  50,  0, 1,0,  -50});
    tbl.push_back('{0,0,0, 100, -100, 2'b01, 2'b01, 1,0,  50,  0, 1,0,  -50});
    tbl.push_back('{0,0,0, 100, -100, 2'b01, 2'b01, 1,0,  50,  0, 1,0,  -50});
    tbl.push_back('{1,0,1, 100,    0, 2'b00, 2'b00, 0,0,   0,  0, 0,0,    0});
    tbl.push_back('{0,0,1,   5,    0, 2'b00, 2'b00, 0,0,   5,  0, 0,0,    0});

    #2;
    foreach (tbl[i]) begin
      drive(tbl[i].r, tbl[i].c, tbl[i].e, tbl[i].w0, tbl[i].w1);
      check_all($sformatf("vec%0d", i), tbl[i].now, tbl[i].stk, tbl[i].c0, tbl[i].c1,
                tbl[i].p0, tbl[i].p1, tbl[i].fv, tbl[i].fc, tbl[i].fval);
    end

    for (int i = 0; i < 400; i++) begin
      bit r, c, e;
      int w0, w1;
      r  = (i == 0) || ($urandom_range(0, 99) < 2);
      c  = ($urandom_range(0, 99) < 3);
      e  = ($urandom_range(0, 99) < 80);
      w0 = pick_word();
      w1 = pick_word();
      drive(r, c, e, w0, w1);
      model_step(r, c, e, w0, w1);
      check_all($sformatf("rnd%0d", i), {m_now[1][0], m_now[0][0]}, {m_stk[1][0], m_stk[0][0]},
                m_cnt[0], m_cnt[1], m_pk[0], m_pk[1], m_fv[0], m_fc, m_fval);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
